// File: rtl/riscv_run_controller.sv
// riscv_run_controller
//
// Run controller that sits beside a RISC-V core. It holds the core in reset
// for a fixed number of cycles and then lets it run. While the core runs it
// counts cycles and retired register writes, and it captures the last value
// written to each watched register. The run ends in one of two ways:
//   - halt:    the PC stays the same for HALT_REPEAT comparisons in a row
//   - timeout: the run reaches MAX_CYCLES cycles
// After a halt, pass reports whether every watched register holds its
// expected value.
//
// Ports
//   clk          sole clock, rising edge
//   reset        synchronous, active-high; restarts the whole sequence
//   core_reset   reset driven to the processor
//   pc           processor PC_Out
//   reg_write    processor RegWrite
//   rd           processor destination register
//   write_data   processor WriteData
//   chk_reg      watched register index per channel, channel i at [5i+4:5i]
//   chk_val      expected value per channel, channel i at [XLEN*i +: XLEN]
//   running      high in RUN
//   done         high in HALTED or TIMEOUT
//   timeout      high in TIMEOUT
//   pass         verdict, valid while done
//   cycle_count  RUN cycles elapsed
//   write_count  retired register writes with rd != 0
//   chk_seen     per-channel "written at least once"
//
// state        | meaning
// -------------+-----------------------------------------------------
// S_RESET_HOLD | core held in reset for RST_CYCLES cycles
// S_RUN        | core running, monitors and counters active
// S_HALTED     | PC stuck, everything frozen, pass is the verdict
// S_TIMEOUT    | cycle budget used up, everything frozen, pass = 0

module riscv_run_controller #(
  parameter int XLEN        = 64,
  parameter int RST_CYCLES  = 2,
  parameter int MAX_CYCLES  = 1024,
  parameter int HALT_REPEAT = 3,
  parameter int NUM_CHECKS  = 4,
  parameter int CNT_W       = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       core_reset,
  input  logic [XLEN-1:0]            pc,
  input  logic                       reg_write,
  input  logic [4:0]                 rd,
  input  logic [XLEN-1:0]            write_data,
  input  logic [NUM_CHECKS*5-1:0]    chk_reg,
  input  logic [NUM_CHECKS*XLEN-1:0] chk_val,
  output logic                       running,
  output logic                       done,
  output logic                       timeout,
  output logic                       pass,
  output logic [CNT_W-1:0]           cycle_count,
  output logic [CNT_W-1:0]           write_count,
  output logic [NUM_CHECKS-1:0]      chk_seen
);

  typedef enum logic [1:0] {
    S_RESET_HOLD,
    S_RUN,
    S_HALTED,
    S_TIMEOUT
  } state_e;

  state_e                  state_q;
  logic [CNT_W-1:0]        hold_q;
  logic [CNT_W-1:0]        cycle_q;
  logic [CNT_W-1:0]        write_q;
  logic [CNT_W-1:0]        stable_q;
  logic [CNT_W-1:0]        stable_d;
  logic [XLEN-1:0]         pc_q;
  logic                    pc_valid_q;
  logic [XLEN-1:0]         cap_q [NUM_CHECKS];
  logic [NUM_CHECKS-1:0]   seen_q;
  logic                    core_reset_q;
  logic                    running_q;
  logic                    done_q;
  logic                    timeout_q;

  logic                    wb_valid;
  logic                    halt_hit;
  logic                    limit_hit;
  logic [NUM_CHECKS-1:0]   match_d;

  // The PC compare is skipped on the first RUN cycle because pc_q holds
  // nothing from this run yet.
  always_comb begin
    stable_d  = (pc_valid_q && (pc == pc_q)) ? stable_q + 1'b1 : '0;
    halt_hit  = (stable_d == CNT_W'(HALT_REPEAT));
    limit_hit = (cycle_q == CNT_W'(MAX_CYCLES - 1));
    wb_valid  = reg_write && (rd != 5'd0);
  end

  // A channel watching x0 never captures anything, so it passes only when
  // it expects zero.
  always_comb begin
    match_d = '0;
    for (int i = 0; i < NUM_CHECKS; i++) begin
      if (chk_reg[5*i +: 5] == 5'd0)
        match_d[i] = (chk_val[XLEN*i +: XLEN] == '0);
      else
        match_d[i] = seen_q[i] && (cap_q[i] == chk_val[XLEN*i +: XLEN]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_RESET_HOLD;
      hold_q       <= '0;
      cycle_q      <= '0;
      write_q      <= '0;
      stable_q     <= '0;
      pc_q         <= '0;
      pc_valid_q   <= 1'b0;
      seen_q       <= '0;
      core_reset_q <= 1'b1;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      for (int i = 0; i < NUM_CHECKS; i++) cap_q[i] <= '0;
    end else begin
      case (state_q)
        S_RESET_HOLD: begin
          hold_q <= hold_q + 1'b1;
          if (hold_q == CNT_W'(RST_CYCLES - 1)) begin
            state_q      <= S_RUN;
            core_reset_q <= 1'b0;
            running_q    <= 1'b1;
          end
        end
        S_RUN: begin
          cycle_q    <= cycle_q + 1'b1;
          pc_q       <= pc;
          pc_valid_q <= 1'b1;
          stable_q   <= stable_d;
          // The edge leaving RUN still records its writeback.
          if (wb_valid) begin
            write_q <= write_q + 1'b1;
            for (int i = 0; i < NUM_CHECKS; i++) begin
              if (chk_reg[5*i +: 5] == rd) begin
                cap_q[i]  <= write_data;
                seen_q[i] <= 1'b1;
              end
            end
          end
          // Halt takes priority over a timeout on the same edge.
          if (halt_hit) begin
            state_q   <= S_HALTED;
            running_q <= 1'b0;
            done_q    <= 1'b1;
          end else if (limit_hit) begin
            state_q   <= S_TIMEOUT;
            running_q <= 1'b0;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
          end
        end
        default: begin
          // HALTED and TIMEOUT are terminal until reset.
        end
      endcase
    end
  end

  assign core_reset  = core_reset_q;
  assign running     = running_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign pass        = (state_q == S_HALTED) && (&match_d);
  assign cycle_count = cycle_q;
  assign write_count = write_q;
  assign chk_seen    = seen_q;

endmodule

// File: tb/tb_riscv_run_controller.sv
module tb_riscv_run_controller;

  localparam int XLEN        = 64;
  localparam int RST_CYCLES  = 2;
  localparam int MAX_CYCLES  = 16;
  localparam int HALT_REPEAT = 3;
  localparam int NUM_CHECKS  = 4;
  localparam int CNT_W       = 32;

  localparam int M_HOLD    = 0;
  localparam int M_RUN     = 1;
  localparam int M_HALTED  = 2;
  localparam int M_TIMEOUT = 3;

  logic                       clk = 1'b0;
  logic                       reset;
  logic                       core_reset;
  logic [XLEN-1:0]            pc;
  logic                       reg_write;
  logic [4:0]                 rd;
  logic [XLEN-1:0]            write_data;
  logic [NUM_CHECKS*5-1:0]    chk_reg;
  logic [NUM_CHECKS*XLEN-1:0] chk_val;
  logic                       running;
  logic                       done;
  logic                       timeout;
  logic                       pass;
  logic [CNT_W-1:0]           cycle_count;
  logic [CNT_W-1:0]           write_count;
  logic [NUM_CHECKS-1:0]      chk_seen;

  int errors = 0;
  int checks = 0;

  riscv_run_controller #(
    .XLEN(XLEN), .RST_CYCLES(RST_CYCLES), .MAX_CYCLES(MAX_CYCLES),
    .HALT_REPEAT(HALT_REPEAT), .NUM_CHECKS(NUM_CHECKS), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .core_reset(core_reset), .pc(pc),
    .reg_write(reg_write), .rd(rd), .write_data(write_data),
    .chk_reg(chk_reg), .chk_val(chk_val), .running(running), .done(done),
    .timeout(timeout), .pass(pass), .cycle_count(cycle_count),
    .write_count(write_count), .chk_seen(chk_seen)
  );

  always #5 clk = ~clk;

  // Behavioural reference: tracks the run as a phase plus plain counters.
  bit              m_known = 0;
  int              m_mode;
  int              m_hold_left;
  int              m_cycles;
  int              m_writes;
  int              m_same_run;
  bit              m_have_prev;
  logic [XLEN-1:0] m_prev_pc;
  logic [XLEN-1:0] m_cap [NUM_CHECKS];
  bit              m_seen [NUM_CHECKS];

  always @(posedge clk) begin
    if (reset === 1'b1) begin
      m_known     = 1;
      m_mode      = M_HOLD;
      m_hold_left = RST_CYCLES;
      m_cycles    = 0;
      m_writes    = 0;
      m_same_run  = 0;
      m_have_prev = 0;
      m_prev_pc   = '0;
      for (int i = 0; i < NUM_CHECKS; i++) begin
        m_cap[i]  = '0;
        m_seen[i] = 0;
      end
    end else if (m_known) begin
      if (m_mode == M_HOLD) begin
        m_hold_left = m_hold_left - 1;
        if (m_hold_left == 0) m_mode = M_RUN;
      end else if (m_mode == M_RUN) begin
        m_cycles = m_cycles + 1;
        if (reg_write && rd != 0) begin
          m_writes = m_writes + 1;
          for (int i = 0; i < NUM_CHECKS; i++)
            if (int'(chk_reg[5*i +: 5]) == int'(rd)) begin
              m_cap[i]  = write_data;
              m_seen[i] = 1;
            end
        end
        if (m_have_prev && pc == m_prev_pc) m_same_run = m_same_run + 1;
        else m_same_run = 0;
        m_prev_pc   = pc;
        m_have_prev = 1;
        if (m_same_run >= HALT_REPEAT) m_mode = M_HALTED;
        else if (m_cycles >= MAX_CYCLES) m_mode = M_TIMEOUT;
      end
    end
  end

  function automatic logic model_pass();
    if (m_mode != M_HALTED) return 1'b0;
    for (int i = 0; i < NUM_CHECKS; i++) begin
      if (chk_reg[5*i +: 5] == 5'd0) begin
        if (chk_val[XLEN*i +: XLEN] != '0) return 1'b0;
      end else if (!m_seen[i] || m_cap[i] != chk_val[XLEN*i +: XLEN]) begin
        return 1'b0;
      end
    end
    return 1'b1;
  endfunction

  function automatic logic [NUM_CHECKS-1:0] model_seen();
    logic [NUM_CHECKS-1:0] s;
    for (int i = 0; i < NUM_CHECKS; i++) s[i] = m_seen[i];
    return s;
  endfunction

  // Cycle-by-cycle compare against the model, 1 time unit after each edge.
  always @(posedge clk) begin
    #1;
    if (m_known) begin
      logic [4:0] exp_flags;
      logic [4:0] act_flags;
      exp_flags = {m_mode == M_HOLD, m_mode == M_RUN,
                   m_mode == M_HALTED || m_mode == M_TIMEOUT,
                   m_mode == M_TIMEOUT, model_pass()};
      act_flags = {core_reset, running, done, timeout, pass};
      checks++;
      if (act_flags !== exp_flags) begin
        errors++;
        $display("FAIL flags t=%0t got=%b want=%b (core_reset,running,done,timeout,pass)",
                 $time, act_flags, exp_flags);
      end
      checks++;
      if (cycle_count !== CNT_W'(m_cycles)) begin
        errors++;
        $display("FAIL cycle_count t=%0t got=%0d want=%0d", $time, cycle_count, m_cycles);
      end
      checks++;
      if (write_count !== CNT_W'(m_writes)) begin
        errors++;
        $display("FAIL write_count t=%0t got=%0d want=%0d", $time, write_count, m_writes);
      end
      checks++;
      if (chk_seen !== model_seen()) begin
        errors++;
        $display("FAIL chk_seen t=%0t got=%b want=%b", $time, chk_seen, model_seen());
      end
    end
  end

  task automatic lit(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic [63:0] p, input logic we, input logic [4:0] r,
                       input logic [63:0] d);
    pc = p; reg_write = we; rd = r; write_data = d;
    tick();
  endtask

  task automatic set_chk(input int i, input logic [4:0] r, input logic [63:0] v);
    chk_reg[5*i +: 5]       = r;
    chk_val[XLEN*i +: XLEN] = v;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0);
    reset = 1'b0;
  endtask

  // Halt scenario: hold-phase write, three real writes, one x0 write, then a
  // stuck PC. Two writes after halting must be ignored.
  task automatic halt_run(input logic exp_pass, input string tag);
    do_reset();
    lit({tag, "_rst_core_reset"}, core_reset, 1);
    drive(0, 1, 5, 9);
    lit({tag, "_hold_core_reset"}, core_reset, 1);
    drive(0, 0, 0, 0);
    lit({tag, "_run_entry"}, {core_reset, running}, 2'b01);
    lit({tag, "_hold_write_ignored"}, chk_seen, 0);
    drive(0, 1, 5, 7);
    lit({tag, "_first_cycle"}, cycle_count, 1);
    drive(4, 1, 5, 9);
    drive(8, 1, 6, 64'hFFFF_FFFF_FFFF_FFFF);
    drive(12, 1, 0, 5);
    lit({tag, "_x0_filtered"}, write_count, 3);
    drive(12, 0, 0, 0);
    drive(12, 0, 0, 0);
    lit({tag, "_not_yet_done"}, done, 0);
    drive(12, 0, 0, 0);
    lit({tag, "_done"}, {done, timeout}, 2'b10);
    lit({tag, "_pass"}, pass, exp_pass);
    lit({tag, "_cycles"}, cycle_count, 7);
    drive(16, 1, 7, 0);
    drive(20, 1, 5, 1);
    lit({tag, "_frozen_writes"}, write_count, 3);
    lit({tag, "_frozen_seen"}, chk_seen, 4'b0011);
    lit({tag, "_frozen_pass"}, pass, exp_pass);
  endtask

  initial begin
    reset = 1'b1; pc = '0; reg_write = 1'b0; rd = '0; write_data = '0;
    chk_reg = '0; chk_val = '0;

    set_chk(0, 5, 9);
    set_chk(1, 6, 64'hFFFF_FFFF_FFFF_FFFF);
    set_chk(2, 0, 0);
    set_chk(3, 7, 0);
    halt_run(1'b0, "halt_x7_unseen");
    set_chk(3, 0, 0);
    halt_run(1'b1, "halt_pass");

    // Timeout: PC never repeats.
    do_reset();
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    for (int k = 0; k < 20; k++) begin
      drive(64'(4 * k), 0, 0, 0);
      if (k == 14) lit("timeout_not_yet", done, 0);
    end
    lit("timeout_flags", {done, timeout, pass}, 3'b110);
    lit("timeout_cycles_frozen", cycle_count, 16);

    // Halt completes on the same edge that would time out.
    do_reset();
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    for (int k = 1; k <= 16; k++) drive((k <= 12) ? 64'(4 * k) : 64'd1000, 0, 0, 0);
    lit("simul_halt_wins", {done, timeout}, 2'b10);
    lit("simul_cycles", cycle_count, 16);

    // Reset in the middle of a run.
    do_reset();
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    for (int k = 0; k < 10; k++) drive(64'(4 * k), 1, 5'(k % 8), 64'(k));
    lit("midrun_before", cycle_count, 10);
    reset = 1'b1;
    drive(0, 0, 0, 0);
    lit("midrun_reset_flags", {core_reset, running, done}, 3'b100);
    lit("midrun_reset_counts", {cycle_count, write_count}, 0);
    reset = 1'b0;
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    lit("midrun_restart", {core_reset, running}, 2'b01);

    // Random traffic with occasional resets and new watch sets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        for (int i = 0; i < NUM_CHECKS; i++)
          set_chk(i, 5'($urandom_range(0, 7)), 64'($urandom_range(0, 3)));
        reset = 1'b1;
      end else begin
        reset = 1'b0;
      end
      if ($urandom_range(0, 2) != 0) pc = 64'($urandom_range(0, 3) * 4);
      reg_write  = 1'($urandom_range(0, 1));
      rd         = 5'($urandom_range(0, 7));
      write_data = 64'($urandom_range(0, 3));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/riscv_run_controller.md
Name: riscv_run_controller

Overview:
- Parametrised, synthesizable run controller for the RISC-V processor.
- Generates the core reset pulse and counts cycles and register writebacks.
- Detects program halt (PC stuck) or timeout, and self-checks up to NUM_CHECKS watched registers against expected values.
- Sits beside the processor, wired to its PC_Out, RegWrite, rd and WriteData; replaces the hand-timed reset and free-running clock flow with a deterministic pass/fail verdict.

Parameters:
- XLEN, 64, datapath/PC width.
- RST_CYCLES, 2, cycles core_reset is held after controller reset releases; must be >=1.
- MAX_CYCLES, 1024, RUN-cycle budget before timeout; must be >=2.
- HALT_REPEAT, 3, consecutive unchanged-PC comparisons that constitute a halt; must be >=1.
- NUM_CHECKS, 4, number of watched register channels.
- CNT_W, 32, counter width; must be wide enough to hold MAX_CYCLES.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- core_reset  out  1  reset driven to the processor.
- pc  in  XLEN  processor PC_Out.
- reg_write  in  1  processor RegWrite.
- rd  in  5  processor destination register.
- write_data  in  XLEN  processor WriteData.
- chk_reg  in  NUM_CHECKS*5  watched register index per channel; channel i occupies bits [5i+4:5i].
- chk_val  in  NUM_CHECKS*XLEN  expected final value per channel; channel i occupies bits [XLEN*i+XLEN-1:XLEN*i].
- running  out  1  high in RUN.
- done  out  1  high in HALTED or TIMEOUT.
- timeout  out  1  high in TIMEOUT.
- pass  out  1  verdict, valid while done.
- cycle_count  out  CNT_W  RUN cycles elapsed.
- write_count  out  CNT_W  retired register writes (rd!=0).
- chk_seen  out  NUM_CHECKS  per-channel "written at least once".

Behaviour:
- Reset (clk edge with reset=1):
  - state=RESET_HOLD, hold counter=0.
  - core_reset=1; running, done, timeout, pass = 0.
  - cycle_count, write_count, stable counter, chk_seen and all capture registers = 0.
  - Reset asserted in any state, including mid-RUN or after done, restarts the whole sequence.
- State machine (one-hot or binary, registered). States: RESET_HOLD, RUN, HALTED, TIMEOUT.
- RESET_HOLD:
  - core_reset=1. The hold counter increments each cycle.
  - When hold counter == RST_CYCLES-1, go to RUN.
  - Result: core_reset stays high during reset plus exactly RST_CYCLES cycles after reset falls.
- RUN:
  - core_reset=0, running=1, cycle_count += 1 each cycle.
  - pc_q registers pc every RUN cycle. In the first RUN cycle pc_q is invalid (a valid flag is cleared), so no comparison is made that cycle.
  - Stable counter: increments when valid and pc == pc_q; otherwise clears to 0.
  - Halt: the stable counter reaching HALT_REPEAT on this edge moves the FSM to HALTED.
  - Timeout: if cycle_count == MAX_CYCLES-1 and the increment happens without a halt, go to TIMEOUT; cycle_count ends at MAX_CYCLES.
  - If halt and timeout occur on the same edge, halt wins.
- Writeback monitor, active only in RUN:
  - If reg_write=1 and rd!=0: write_count += 1.
  - For each channel i with chk_reg[i]==rd: cap[i] <= write_data and chk_seen[i] <= 1. Last write wins.
  - The final cycle of RUN (the edge that enters HALTED/TIMEOUT) still captures.
  - Writes to x0, and all writes outside RUN, are ignored.
- HALTED: done=1. All counters and captures are frozen. pc and writes are ignored.
  - pass is combinational from frozen state: AND over i of (chk_reg[i]==0 ? chk_val[i]==0 : chk_seen[i] && cap[i]==chk_val[i]).
  - A channel watching x0 therefore passes only if its expected value is 0.
- TIMEOUT: done=1, timeout=1, pass=0, everything frozen.
- HALTED and TIMEOUT are exited only by reset.
- Width rules: counters are CNT_W unsigned; comparisons are full XLEN equality.

Test Plan:
- Reset sequencing: reset high 1 cycle, RST_CYCLES=2 -> core_reset high that cycle plus exactly 2 more edges, then running=1, cycle_count=1 after the first RUN edge.
- Halt and pass: pc 0,4,8,12,12,12,12 with HALT_REPEAT=3. Writes x5=7 then x5=9, x6=0xFFFF_FFFF_FFFF_FFFF. chk={x5:9, x6:all-ones, x0:0, x7 unwritten expecting 0} -> done on the edge of the third repeat, pass=0 (x7 unseen). Repeat with chk x7 replaced by x0:0 -> pass=1, write_count=3.
- Timeout: MAX_CYCLES=16, pc incrementing by 4 forever -> timeout=done=1 after 16 RUN cycles, cycle_count=16, pass=0, cycle_count frozen thereafter.
- Simultaneous edge: halt condition completing on the same edge cycle_count hits MAX_CYCLES-1 -> HALTED, timeout=0.
- x0 filtering and non-RUN writes: reg_write with rd=0 and write_data=5 in RUN -> write_count unchanged. Writes during RESET_HOLD or HALTED -> no capture, counts unchanged.
- Mid-run reset: assert reset at cycle 10 of RUN -> every output returns to reset values the next edge and the sequence restarts with core_reset held RST_CYCLES cycles.
